// File: rtl/led_blink_pkg.sv
// Shared definitions for the multi-channel LED blink controller.
// Mode encodings are common to the top level and the per-channel engine.
package led_blink_pkg;

    localparam int unsigned LED_MODE_W = 2;

    localparam logic [LED_MODE_W-1:0] LED_MODE_OFF   = 2'b00;
    localparam logic [LED_MODE_W-1:0] LED_MODE_ON    = 2'b01;
    localparam logic [LED_MODE_W-1:0] LED_MODE_BLINK = 2'b10;
    localparam logic [LED_MODE_W-1:0] LED_MODE_PULSE = 2'b11;

endpackage

// File: rtl/led_blink_ch.sv
// One LED channel: half-period counter, phase bit, burst counter and registered LED drive.
// Advances only on the shared one-clock tick_rise_i strobe.
module led_blink_ch
    import led_blink_pkg::*;
#(
    parameter int unsigned HALF_TICKS = 1,
    parameter int unsigned BURST_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_rise_i,
    input  logic [LED_MODE_W-1:0] mode_i,
    input  logic                  trig_i,
    input  logic [BURST_W-1:0]    burst_len_i,
    output logic                  led_o,
    output logic                  busy_o
);

    localparam int unsigned    HcW    = $clog2(HALF_TICKS + 1);
    localparam logic [HcW-1:0] HcLast = HcW'(HALF_TICKS - 1);

    logic [LED_MODE_W-1:0] mode_q, mode_d;
    logic [HcW-1:0]        hc_q, hc_d;
    logic                  ph_q, ph_d;
    logic [BURST_W-1:0]    rem_q, rem_d;
    logic                  busy_q, busy_d;
    logic                  led_q, led_d;
    logic [BURST_W-1:0]    rem_load;
    logic                  hc_wrap;

    assign rem_load = (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
    assign hc_wrap  = tick_rise_i && (hc_q == HcLast);

    always_comb begin
        mode_d = mode_i;
        hc_d   = hc_q;
        ph_d   = ph_q;
        rem_d  = rem_q;
        busy_d = busy_q;
        if (mode_i != mode_q) begin
            // Any mode change restarts the channel; BLINK always opens with its on phase.
            hc_d   = '0;
            ph_d   = (mode_i == LED_MODE_BLINK);
            rem_d  = '0;
            busy_d = 1'b0;
        end else begin
            case (mode_i)
                LED_MODE_BLINK: begin
                    if (hc_wrap) begin
                        hc_d = '0;
                        ph_d = ~ph_q;
                    end else if (tick_rise_i) begin
                        hc_d = hc_q + 1'b1;
                    end
                end
                LED_MODE_PULSE: begin
                    if (!busy_q) begin
                        if (trig_i) begin
                            busy_d = 1'b1;
                            ph_d   = 1'b1;
                            hc_d   = '0;
                            rem_d  = rem_load;
                        end
                    end else begin
                        if (trig_i) begin
                            rem_d = rem_load;
                        end
                        if (hc_wrap) begin
                            hc_d = '0;
                            if (ph_q) begin
                                ph_d = 1'b0;
                            end else if (trig_i) begin
                                ph_d = 1'b1;
                            end else if (rem_q == BURST_W'(1)) begin
                                busy_d = 1'b0;
                                rem_d  = '0;
                            end else begin
                                rem_d = rem_q - 1'b1;
                                ph_d  = 1'b1;
                            end
                        end else if (tick_rise_i) begin
                            hc_d = hc_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (mode_i)
            LED_MODE_ON:    led_d = 1'b1;
            LED_MODE_BLINK: led_d = ph_d;
            LED_MODE_PULSE: led_d = busy_d & ph_d;
            default:        led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= LED_MODE_OFF;
            hc_q   <= '0;
            ph_q   <= 1'b0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            led_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            hc_q   <= hc_d;
            ph_q   <= ph_d;
            rem_q  <= rem_d;
            busy_q <= busy_d;
            led_q  <= led_d;
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED controller: tick synchroniser/edge detector feeding NUM_CH channel engines.
// Optional inverted output led_n is built when LED_N_OUT_EN is defined.
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int U_DLY      = 1,
    parameter int NUM_CH     = 4,
    parameter int HALF_TICKS = 1,
    parameter int BURST_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic [LED_MODE_W*NUM_CH-1:0]  mode,
    input  logic [NUM_CH-1:0]             trig,
    input  logic [BURST_W*NUM_CH-1:0]     burst_len,
    output logic [NUM_CH-1:0]             led,
    output logic [NUM_CH-1:0]             busy
`ifdef LED_N_OUT_EN
    ,
    output logic [NUM_CH-1:0]             led_n
`endif
);

    // NBA delay only matters for legacy gate-level sims; it has no hardware meaning.
    logic unused_u_dly;
    assign unused_u_dly = (U_DLY != 0);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[0], tick};
        prev_d = sync_q[1];
        rise_d = sync_q[1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        led_blink_ch #(
            .HALF_TICKS (HALF_TICKS),
            .BURST_W    (BURST_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick_rise_i (rise_q),
            .mode_i      (mode[LED_MODE_W*c +: LED_MODE_W]),
            .trig_i      (trig[c]),
            .burst_len_i (burst_len[BURST_W*c +: BURST_W]),
            .led_o       (led[c]),
            .busy_o      (busy[c])
        );
    end

`ifdef LED_N_OUT_EN
    logic [NUM_CH-1:0] led_n_q, led_n_d;

    always_comb begin
        led_n_d = ~led;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_n_q <= '1;
        end else begin
            led_n_q <= led_n_d;
        end
    end

    assign led_n = led_n_q;
`endif

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl (NUM_CH=2, HALF_TICKS=2, BURST_W=4).
// Table vectors, directed multi-cycle sequences and random traffic against a behavioural model.
module tb_led_blink_ctrl;

    localparam int NCH = 2;
    localparam int H   = 2;
    localparam int BW  = 4;

    localparam logic [1:0] M_OFF   = 2'b00;
    localparam logic [1:0] M_ON    = 2'b01;
    localparam logic [1:0] M_BLINK = 2'b10;
    localparam logic [1:0] M_PULSE = 2'b11;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           tick;
    logic [2*NCH-1:0]  mode;
    logic [NCH-1:0]    trig;
    logic [BW*NCH-1:0] burst_len;
    logic [NCH-1:0]    led;
    logic [NCH-1:0]    busy;
`ifdef LED_N_OUT_EN
    logic [NCH-1:0]    led_n;
`endif

    int checks = 0;
    int errors = 0;

    bit tick_en  = 1'b0;
    int tick_per = 20;

    led_blink_ctrl #(
        .U_DLY      (1),
        .NUM_CH     (NCH),
        .HALF_TICKS (H),
        .BURST_W    (BW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .mode      (mode),
        .trig      (trig),
        .burst_len (burst_len),
        .led       (led),
        .busy      (busy)
`ifdef LED_N_OUT_EN
        ,
        .led_n     (led_n)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Tick source: 2-clk-wide pulse every tick_per clocks while enabled.
    initial begin
        int cnt;
        cnt  = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                cnt++;
                if (cnt >= tick_per) cnt = 0;
                tick = (cnt < 2);
            end else begin
                cnt  = 0;
                tick = 1'b0;
            end
        end
    end

    // Behavioural model: a tick edge seen at the pin affects channel state three edges later.
    bit         tq [4];
    int         m_ticks [NCH];
    int         m_left  [NCH];
    bit         m_on    [NCH];
    bit         m_act   [NCH];
    logic [1:0] m_prev  [NCH];
    logic [NCH-1:0] exp_led, exp_busy, exp_led_n;
    bit         m_rise, m_bound;
    logic [1:0] m_mode;
    int         m_load;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) tq[i] = 1'b0;
                for (int c = 0; c < NCH; c++) begin
                    m_ticks[c] = 0; m_left[c] = 0; m_on[c] = 1'b0;
                    m_act[c] = 1'b0; m_prev[c] = M_OFF;
                end
                exp_led   = '0;
                exp_busy  = '0;
                exp_led_n = '1;
            end else begin
                m_rise    = tq[2] && !tq[3];
                exp_led_n = ~exp_led;
                for (int c = 0; c < NCH; c++) begin
                    m_mode  = mode[2*c +: 2];
                    m_load  = (burst_len[BW*c +: BW] == 0) ? 1 : int'(burst_len[BW*c +: BW]);
                    m_bound = m_rise && (m_ticks[c] + 1 == H);
                    if (m_mode != m_prev[c]) begin
                        m_ticks[c] = 0; m_left[c] = 0; m_act[c] = 1'b0;
                        m_on[c] = (m_mode == M_BLINK);
                    end else if (m_mode == M_BLINK) begin
                        if (m_bound) begin m_ticks[c] = 0; m_on[c] = !m_on[c]; end
                        else if (m_rise) m_ticks[c]++;
                    end else if (m_mode == M_PULSE) begin
                        if (!m_act[c]) begin
                            if (trig[c]) begin
                                m_act[c] = 1'b1; m_on[c] = 1'b1; m_ticks[c] = 0; m_left[c] = m_load;
                            end
                        end else begin
                            if (trig[c]) m_left[c] = m_load;
                            if (m_bound) begin
                                m_ticks[c] = 0;
                                if (m_on[c]) m_on[c] = 1'b0;
                                else if (trig[c]) m_on[c] = 1'b1;
                                else if (m_left[c] == 1) begin m_act[c] = 1'b0; m_left[c] = 0; end
                                else begin m_left[c]--; m_on[c] = 1'b1; end
                            end else if (m_rise) m_ticks[c]++;
                        end
                    end
                    m_prev[c]   = m_mode;
                    exp_led[c]  = (m_mode == M_ON) || (m_mode == M_BLINK && m_on[c]) ||
                                  (m_mode == M_PULSE && m_act[c] && m_on[c]);
                    exp_busy[c] = (m_mode == M_PULSE) && m_act[c];
                end
                for (int i = 3; i > 0; i--) tq[i] = tq[i-1];
                tq[0] = tick;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("model_led", led, exp_led);
                chk("model_busy", busy, exp_busy);
`ifdef LED_N_OUT_EN
                chk("model_led_n", led_n, exp_led_n);
`endif
            end
        end
    end

    // Length in clocks of the current level of led[ch]; 200 signals a stuck output.
    task automatic measure(input int ch, output int len);
        logic cur;
        cur = led[ch];
        len = 0;
        while (led[ch] == cur && len < 200) begin
            @(negedge clk);
            len++;
        end
    endtask

    // Follows a running ch0 burst until busy drops; counts pulses and checks full pulse widths.
    task automatic count_burst(input int retrig_at, output int pulses);
        int cyc, hi;
        bit prev_led, done;
        pulses = 1; hi = 0; prev_led = 1'b1; cyc = 0; done = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            trig[0] = 1'b0;
            if (!busy[0]) begin
                chk("led_at_burst_end", led[0], 0);
                done = 1'b1;
            end else begin
                if (led[0] && !prev_led) begin
                    pulses++;
                    hi = 0;
                    if (pulses == retrig_at) trig[0] = 1'b1;
                end
                if (led[0]) hi++;
                if (!led[0] && prev_led && pulses > 1) chk("pulse_width", hi, 40);
                prev_led = led[0];
            end
        end
        if (!done) chk("burst_timeout", cyc, 0);
    endtask

    task automatic start_burst(input int len);
        burst_len[3:0] = 4'(len);
        trig[0] = 1'b1;
        @(negedge clk);
        trig[0] = 1'b0;
        chk("trig_busy", busy[0], 1);
        chk("trig_led", led[0], 1);
    endtask

    typedef struct {
        logic [3:0] mode;
        logic [1:0] trig;
        logic [1:0] led;
        logic [1:0] busy;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int len, pulses;
        tbl[0]  = '{4'b0000, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{4'b0001, 2'b00, 2'b01, 2'b00};
        tbl[2]  = '{4'b0000, 2'b00, 2'b00, 2'b00};
        tbl[3]  = '{4'b0100, 2'b00, 2'b10, 2'b00};
        tbl[4]  = '{4'b0101, 2'b00, 2'b11, 2'b00};
        tbl[5]  = '{4'b0101, 2'b11, 2'b11, 2'b00};
        tbl[6]  = '{4'b0000, 2'b11, 2'b00, 2'b00};
        tbl[7]  = '{4'b0011, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{4'b0011, 2'b01, 2'b01, 2'b01};
        tbl[9]  = '{4'b0011, 2'b00, 2'b01, 2'b01};
        tbl[10] = '{4'b0000, 2'b00, 2'b00, 2'b00};
        tbl[11] = '{4'b1000, 2'b00, 2'b10, 2'b00};
        tbl[12] = '{4'b1000, 2'b00, 2'b10, 2'b00};
        tbl[13] = '{4'b0000, 2'b00, 2'b00, 2'b00};

        rst_n = 1'b0; mode = '0; trig = '0; burst_len = 8'h33;
        repeat (3) @(negedge clk);
        chk("reset_led", led, 0);
        chk("reset_busy", busy, 0);
`ifdef LED_N_OUT_EN
        chk("reset_led_n", led_n, 3);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            mode = tbl[i].mode;
            trig = tbl[i].trig;
            @(negedge clk);
            chk($sformatf("vec%0d_led", i), led, tbl[i].led);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
        end

        tick_en = 1'b1;
        repeat (30) @(negedge clk);

        // BLINK on ch1: first phase is partial, then ten 40-clk half periods.
        mode = {M_BLINK, M_OFF};
        @(negedge clk);
        chk("blink_entry_led", led[1], 1);
        measure(1, len);
        for (int k = 0; k < 10; k++) begin
            measure(1, len);
            chk($sformatf("blink_half%0d", k), len, 40);
        end

        // PULSE bursts on ch0 while ch1 keeps blinking.
        mode = {M_BLINK, M_PULSE};
        repeat (3) @(negedge clk);
        start_burst(3);
        count_burst(0, pulses);
        chk("burst3_pulses", pulses, 3);
        repeat (5) @(negedge clk);
        start_burst(0);
        count_burst(0, pulses);
        chk("burst0_pulses", pulses, 1);
        repeat (5) @(negedge clk);
        start_burst(2);
        count_burst(2, pulses);
        chk("retrig_pulses", pulses, 3);

        // PULSE -> BLINK during an on phase.
        repeat (5) @(negedge clk);
        start_burst(5);
        repeat (3) @(negedge clk);
        mode = {M_BLINK, M_BLINK};
        @(negedge clk);
        chk("modechg_busy", busy[0], 0);
        chk("modechg_led", led[0], 1);

        // Asynchronous reset during a burst.
        mode = {M_BLINK, M_PULSE};
        repeat (3) @(negedge clk);
        start_burst(5);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", led, 0);
        chk("async_rst_busy", busy, 0);
`ifdef LED_N_OUT_EN
        chk("async_rst_led_n", led_n, 3);
`endif
        @(negedge clk);
        mode = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_rst_led", led, 0);
        chk("post_rst_busy", busy, 0);

        // Random traffic; the model checker compares every cycle.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (n % 500 == 0) tick_per = $urandom_range(4, 14);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 59) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
                trig[c] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 7) == 0) burst_len[BW*c +: BW] = 4'($urandom_range(0, 15));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
